fe_pow: RTL
===========

// Module: fe_pow
// PURPOSE
//  Field exponentiation controller for GF(2^255-19): computes result = x^E mod p, with E a parameter.
//  Default E = p-2, which gives the field inverse.
//  Sits directly upstream of one femul instance: drives its start/a_in/b_in and consumes its done/out.
//  Uses left-to-right square-and-multiply and issues one multiplication at a time.
// PARAMETERS
//  EW           255             exponent width in bits; EW>=1, E[EW-1] must be 1
//  E            2^255-21        exponent (p-2), EW bits
//  DRAIN_CYCLES 64              post-reset cycles before ready rises; exceeds femul start->done latency
// PORTS
//  clock      in   1    rising-edge clock
//  reset_n    in   1    asynchronous, active-low reset
//  start      in   1    one-cycle request; x sampled when start & ready
//  x          in   255  base, canonical (< p)
//  ready      out  1    block idle and able to accept start
//  done       out  1    one-cycle pulse; result valid from this cycle
//  result     out  255  x^E mod p; held until the next done
//  mul_start  out  1    to femul.start
//  mul_a      out  255  to femul.a_in
//  mul_b      out  255  to femul.b_in
//  mul_ready  in   1    from femul.ready
//  mul_done   in   1    from femul.done
//  mul_out    in   255  from femul.out; sampled only when mul_done=1
// BEHAVIOUR
//  Reset (async, reset_n=0): ready=0, done=0, result=0, mul_start=0, mul_a=mul_b=0; state=DRAIN.
//    Internal registers acc, base and bit index are cleared.
//  States: DRAIN, IDLE, SQ_ISS, SQ_WAIT, MU_ISS, MU_WAIT, FIN.
//  DRAIN: counts DRAIN_CYCLES. This flushes any femul op left in flight, since femul has no reset.
//    Then go to IDLE with ready=1.
//  IDLE: on start, latch base=x and acc=x, set i=EW-2, drop ready.
//    If EW==1, go to FIN; otherwise go to SQ_ISS.
//  SQ_ISS: wait for mul_ready=1. Then drive mul_a=mul_b=acc with mul_start=1 for exactly one cycle.
//    Then go to SQ_WAIT.
//  SQ_WAIT: on mul_done, acc<=mul_out.
//    If E[i]=1, go to MU_ISS. Otherwise, if i==0 go to FIN, else i<=i-1 and go to SQ_ISS.
//  MU_ISS: as SQ_ISS, with mul_a=acc and mul_b=base.
//  MU_WAIT: on mul_done, acc<=mul_out. If i==0 go to FIN, else i<=i-1 and go to SQ_ISS.
//  FIN: result<=acc, done=1 for one cycle, ready=1, then IDLE.
//  mul_a/mul_b are stable from the mul_start cycle until mul_done; they change only in *_ISS states.
//  mul_done outside *_WAIT is ignored. At most one femul op is outstanding at any time.
//  start while ready=0 (busy or DRAIN) is ignored; x is not re-sampled.
//  start in the same cycle as the FIN done pulse is ignored; ready is high only from the next cycle.
//  Reset mid-operation: abort, discard acc, result returns to 0, re-enter DRAIN.
//  Per iteration: 1 issue cycle + femul latency per multiplication, plus 1 FIN cycle.
//  No arithmetic is done in this block; all reduction is done by femul.
// CONFIGURATION
//  FE_POW_CONSTTIME_EN defined:
//    - A multiply is issued on every bit; SQ_WAIT always goes to MU_ISS.
//    - When E[i]=0, the MU_WAIT result is discarded and acc is kept.
//    - The mul_start count and the total latency are independent of E's bit pattern and of x.
//  Not defined:
//    - Multiplies are skipped for zero bits, as in the state transitions above.
// TESTING (femul instance connected; default E=p-2 unless stated)
//  1 reset, hold start=1 -> ready=0 for DRAIN_CYCLES, no mul_start, start ignored; then ready=1.
//  2 x=2 -> result=2^254-9 ((p+1)/2); exactly 506 mul_start pulses (254 squarings + 252 multiplies).
//    With FE_POW_CONSTTIME_EN: 508 pulses, and the same cycle count as for x=3.
//  3 x=1 -> result=1.
//    x=0 -> result=0.
//    x=p-1 -> result=p-1.
//    Each case gives a single done pulse.
//  4 EW=3, E=5, x=3 -> result=243; mul_start pulses: sq, sq, mul (3), or 4 with CONSTTIME.
//    EW=1, E=1, x=7 -> done 2 cycles after start, result=7, no mul_start.
//  5 Pulse start again while busy with x=5 -> ignored; result matches the first x.
//    mul_a/mul_b are unchanged between each mul_start and its mul_done.
//  6 Assert reset_n=0 after 100 operation cycles -> outputs cleared asynchronously, DRAIN re-entered.
//    A fresh x=2 run then returns 2^254-9; stale femul done pulses have no effect.

Source files
------------

// File: rtl/fe_pow.sv
// fe_pow -- field exponentiation controller for GF(2^255-19).
//
// Computes result = x^E mod p with left-to-right square-and-multiply.
// All arithmetic is delegated to one external femul instance; this block
// only sequences operands and captures products. Default E = p-2 (inverse).
//
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   start, x                request; x latched when start & ready
//   ready                   idle and able to accept start
//   done, result            one-cycle completion pulse, result held until next done
//   mul_start, mul_a, mul_b drive femul.start / a_in / b_in
//   mul_ready, mul_done,    from femul.ready / done / out
//   mul_out
//
// Optional build macro: FE_POW_CONSTTIME_EN
//   Issues a multiply on every exponent bit and discards the product for
//   zero bits, so mul_start count and latency do not depend on E or x.

module fe_pow #(
    parameter int unsigned      EW           = 255,
    parameter logic [EW-1:0]    E            = {{250{1'b1}}, 5'b01011},
    parameter int unsigned      DRAIN_CYCLES = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [254:0] x,
    output logic         ready,
    output logic         done,
    output logic [254:0] result,
    output logic         mul_start,
    output logic [254:0] mul_a,
    output logic [254:0] mul_b,
    input  logic         mul_ready,
    input  logic         mul_done,
    input  logic [254:0] mul_out
);

    localparam int unsigned  IW    = (EW > 1) ? $clog2(EW) : 1;
    localparam int unsigned  CW    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [IW-1:0] I_TOP = (EW > 1) ? IW'(EW - 2) : '0;

`ifdef FE_POW_CONSTTIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_DRAIN, S_IDLE, S_SQ_ISS, S_SQ_WAIT, S_MU_ISS, S_MU_WAIT, S_FIN
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [IW-1:0]  idx_q;
    logic [254:0]   acc_q, base_q, result_q, mul_a_q, mul_b_q;
    logic           ready_q, done_q, mul_start_q;

    logic           bit_set, last_bit, mul_take;
    logic [254:0]   acc_d;

    assign bit_set  = E[idx_q];
    assign last_bit = (idx_q == '0);
    // femul cannot answer in the cycle it is handed the operands, so a
    // done coincident with our own start pulse is a leftover and is dropped.
    assign mul_take = mul_done & ~mul_start_q;
    // Multiply product for a zero bit is a dummy op in constant-time mode.
    assign acc_d    = (CT && !bit_set) ? acc_q : mul_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_DRAIN;
            cnt_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            base_q      <= '0;
            result_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                // femul has no reset; wait out any op it may still be running.
                S_DRAIN: begin
                    if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                // ready is low in the done cycle, so start is only taken
                // from the following cycle on.
                S_IDLE: begin
                    if (start && ready_q) begin
                        base_q  <= x;
                        acc_q   <= x;
                        idx_q   <= I_TOP;
                        ready_q <= 1'b0;
                        state_q <= (EW == 1) ? S_FIN : S_SQ_ISS;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_SQ_ISS: begin
                    if (mul_ready) begin
                        mul_start_q <= 1'b1;
                        mul_a_q     <= acc_q;
                        mul_b_q     <= acc_q;
                        state_q     <= S_SQ_WAIT;
                    end
                end
                S_SQ_WAIT: begin
                    if (mul_take) begin
                        acc_q <= mul_out;
                        if (CT || bit_set) begin
                            state_q <= S_MU_ISS;
                        end else if (last_bit) begin
                            state_q <= S_FIN;
                        end else begin
                            idx_q   <= idx_q - IW'(1);
                            state_q <= S_SQ_ISS;
                        end
                    end
                end
                S_MU_ISS: begin
                    if (mul_ready) begin
                        mul_start_q <= 1'b1;
                        mul_a_q     <= acc_q;
                        mul_b_q     <= base_q;
                        state_q     <= S_MU_WAIT;
                    end
                end
                S_MU_WAIT: begin
                    if (mul_take) begin
                        acc_q <= acc_d;
                        if (last_bit) begin
                            state_q <= S_FIN;
                        end else begin
                            idx_q   <= idx_q - IW'(1);
                            state_q <= S_SQ_ISS;
                        end
                    end
                end
                S_FIN: begin
                    result_q <= acc_q;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_DRAIN;
            endcase
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign result    = result_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule
